icache: RTL
===========

// Module: icache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
//  It serves IF fetches in one cycle on a hit.
//  On a miss it drives mem_ctrl's instruction-read port, waits for the 4-byte assembled word, fills the line and returns the instruction.
//  It absorbs IF redirects (branch/jump flush) without aborting an in-flight mem_ctrl read.
// PARAMETERS
//  ADDR_W   32  byte address width; tag = ADDR_W-INDEX_W-2 bits
//  INDEX_W  6   log2(lines); default 64 lines x 32 bits
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-low reset
//  if_req_i    in   1       fetch request, sampled when if_ready_o=1
//  if_pc_i     in   ADDR_W  fetch address; bits [1:0] ignored
//  if_flush_i  in   1       IF redirect; discard any pending/in-flight result
//  fence_i_i   in   1       invalidate all lines (FENCE.I)
//  if_ready_o  out  1       block can accept a request this cycle
//  if_valid_o  out  1       one-cycle pulse: if_inst_o valid for last accepted pc
//  if_inst_o   out  32      fetched instruction
//  mc_req_o    out  1       level: refill read outstanding to mem_ctrl
//  mc_raddr_o  out  ADDR_W  word-aligned refill address, stable while mc_req_o=1
//  mc_done_i   in   1       mem_ctrl read-complete pulse (if_mem_ctrl_done)
//  mc_rdata_i  in   32      mem_ctrl assembled word, valid with mc_done_i
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all valid bits cleared; state=IDLE
//   - if_valid_o=0, if_inst_o=0, mc_req_o=0, mc_raddr_o=0
//   - if_ready_o=1 after reset release
//  Storage: valid[2^INDEX_W] in flops; tag/data arrays in flops (no RAM macro).
//  States:
//   IDLE
//    - if_ready_o=1
//    - if_req_i && hit: next cycle if_valid_o=1, if_inst_o=data; stay IDLE
//    - if_req_i && miss: latch pc, mc_raddr_o={pc[ADDR_W-1:2],2'b00}, mc_req_o=1 next cycle -> REFILL
//   REFILL
//    - if_ready_o=0; mc_req_o=1; wait for mc_done_i
//    - on mc_done_i: write tag/data, set valid, mc_req_o=0
//    - next cycle: if_valid_o=1, if_inst_o=mc_rdata_i (unless dropped) -> IDLE
//  Latency:
//   - hit: 1 cycle req->valid
//   - miss: mc_done latency + 1; back-to-back hits at 1/cycle
//  Flush:
//   - if_flush_i suppresses any if_valid_o due next cycle
//   - in REFILL, flush sets a drop flag: refill still completes and fills the line, no if_valid_o
//   - if_req_i in the same cycle as if_flush_i (IDLE) is accepted: it is the redirected pc
//  Fence:
//   - fence_i_i clears all valid bits at the next edge; the lookup in that cycle is forced to miss
//   - if fence_i_i coincides with mc_done_i, the line is NOT marked valid; data is still returned unless dropped
//  mc_done_i outside REFILL: ignored.
//  Index wraps naturally; tag compares full upper bits; no aliasing.
// CONFIGURATION
//  ICACHE_EN defined:
//   - behaviour as above
//  ICACHE_EN undefined:
//   - arrays not instantiated; every request takes the REFILL path
//   - hit latency = miss latency; fence_i_i is a no-op
//   - port list unchanged
// TESTING
//  1. Cold miss: req pc=0x0000_0010, mc_done after 9 cycles with rdata=0x0050_0093
//     -> mc_raddr_o=0x10 held; if_valid_o 1 cycle after done; inst=0x0050_0093
//  2. Hit after fill: req pc=0x10 again -> if_valid_o next cycle, mc_req_o stays 0
//  3. Conflict: fill 0x10, then req 0x110 (same index, INDEX_W=6)
//     -> miss, refill; later req 0x10 misses again
//  4. Flush mid-refill: req 0x20 (miss), if_flush_i 3 cycles later
//     -> no if_valid_o; line filled; next req 0x20 hits in 1 cycle
//  5. fence_i_i after filling 0x10 and 0x14 -> both subsequent reqs miss
//  6. Async reset asserted during REFILL -> mc_req_o=0 immediately; later req 0x10 misses

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
//
// Hits return one cycle after the request. Misses issue a word-aligned read to
// mem_ctrl, hold it until mc_done_i, fill the line and return the word one cycle later.
// An IF redirect during a refill lets the read finish and the line fill, but
// suppresses the returned word.
//
// Configuration macro: ICACHE_EN. When it is undefined, no arrays are built, every
// request takes the refill path, and fence_i_i has no effect. The port list is the
// same in both builds.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   if_req_i, if_pc_i fetch request and byte address (bits [1:0] ignored)
//   if_flush_i        IF redirect: drop any pending or in-flight result
//   fence_i_i         invalidate all lines
//   if_ready_o        request can be accepted this cycle
//   if_valid_o        one-cycle pulse: if_inst_o holds the fetched word
//   if_inst_o         fetched instruction
//   mc_req_o          refill read outstanding (level)
//   mc_raddr_o        word-aligned refill address, stable while mc_req_o=1
//   mc_done_i         mem_ctrl read-complete pulse
//   mc_rdata_i        mem_ctrl word, valid with mc_done_i
module icache #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              if_flush_i,
    input  logic              fence_i_i,
    output logic              if_ready_o,
    output logic              if_valid_o,
    output logic [31:0]       if_inst_o,
    output logic              mc_req_o,
    output logic [ADDR_W-1:0] mc_raddr_o,
    input  logic              mc_done_i,
    input  logic [31:0]       mc_rdata_i
);

    localparam int unsigned TagW  = ADDR_W - INDEX_W - 2;
    localparam int unsigned Lines = 1 << INDEX_W;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              drop_q, drop_d;
    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;

    logic              hit;
    logic [31:0]       hit_data;
    logic              fill_en;

    assign fill_en = (state_q == StRefill) && mc_done_i;

`ifdef ICACHE_EN
    logic [Lines-1:0]   line_valid_q;
    logic [TagW-1:0]    tag_q  [Lines];
    logic [31:0]        data_q [Lines];
    logic [INDEX_W-1:0] lk_idx, fill_idx;
    logic [TagW-1:0]    lk_tag;
    logic               unused_bits;

    assign lk_idx      = if_pc_i[INDEX_W+1:2];
    assign lk_tag      = if_pc_i[ADDR_W-1:INDEX_W+2];
    assign fill_idx    = raddr_q[INDEX_W+1:2];
    assign unused_bits = ^if_pc_i[1:0];

    // A fence in the lookup cycle forces a miss so no stale line is returned.
    assign hit      = line_valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !fence_i_i;
    assign hit_data = data_q[lk_idx];

    // Fence wins over a same-cycle fill: the freshly fetched line stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid_q <= '0;
        end else if (fence_i_i) begin
            line_valid_q <= '0;
        end else if (fill_en) begin
            line_valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; line_valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= raddr_q[ADDR_W-1:INDEX_W+2];
            data_q[fill_idx] <= mc_rdata_i;
        end
    end
`else
    logic unused_bits;

    assign hit         = 1'b0;
    assign hit_data    = '0;
    assign unused_bits = ^{fence_i_i, if_pc_i[1:0]};
`endif

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            raddr_q <= '0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        drop_d  = drop_q;
        valid_d = 1'b0;
        inst_d  = inst_q;
        unique case (state_q)
            StIdle: begin
                // A request alongside a flush is the redirected pc, so it is served.
                if (if_req_i) begin
                    if (hit) begin
                        valid_d = 1'b1;
                        inst_d  = hit_data;
                    end else begin
                        state_d = StRefill;
                        raddr_d = {if_pc_i[ADDR_W-1:2], 2'b00};
                        drop_d  = 1'b0;
                    end
                end
            end
            StRefill: begin
                if (mc_done_i) begin
                    state_d = StIdle;
                    if (!drop_q && !if_flush_i) begin
                        valid_d = 1'b1;
                        inst_d  = mc_rdata_i;
                    end
                end else if (if_flush_i) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        if_ready_o = (state_q == StIdle);
        mc_req_o   = (state_q == StRefill);
        if_valid_o = valid_q;
        if_inst_o  = inst_q;
        mc_raddr_o = raddr_q;
    end

endmodule
